// File: rtl/ring_pkt_arb_if.sv
// ring_pkt_arb_if: bundle of the per-port request channels and the shared
// output channel of the packet arbiter.
//   master : arbiter side (consumes requests, drives the output channel)
//   slave  : environment side (drives requests, consumes the output channel)
interface ring_pkt_arb_if #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 8
);
  logic [NUM_PORTS-1:0]       p_srdy;
  logic [NUM_PORTS-1:0]       p_drdy;
  logic [NUM_PORTS*WIDTH-1:0] p_data;
  logic [NUM_PORTS-1:0]       p_eop;
  logic                       o_srdy;
  logic                       o_drdy;
  logic [WIDTH-1:0]           o_data;
  logic                       o_eop;
  logic [NUM_PORTS-1:0]       grant;

  modport master (
    input  p_srdy, p_data, p_eop, o_drdy,
    output p_drdy, o_srdy, o_data, o_eop, grant
  );

  modport slave (
    output p_srdy, p_data, p_eop, o_drdy,
    input  p_drdy, o_srdy, o_data, o_eop, grant
  );
endinterface

// File: rtl/ring_pkt_arb.sv
// ring_pkt_arb: packet-granular round-robin arbiter/mux. A winning port keeps
// the output channel until its eop beat transfers; the next search then starts
// one past the finishing port.
// Optional build macro RING_PKT_ARB_OREG_EN inserts a one-entry output
// register (1-cycle latency, full throughput). Without it the path is
// combinational with zero latency.
module ring_pkt_arb #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 8
) (
  input  logic            clk,
  input  logic            reset,
  ring_pkt_arb_if.master  bus
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_PORTS - 1);

  // Increment a port index with an explicit wrap at NUM_PORTS.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] v);
    if (v == LAST_IDX) begin
      next_idx = {PW{1'b0}};
    end else begin
      next_idx = v + PW'(1);
    end
  endfunction

  // Port index (base + offset) modulo NUM_PORTS, without relying on overflow.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_PORTS) begin
      s = s - NUM_PORTS;
    end else begin
      s = s;
    end
    wrap_add = PW'(s);
  endfunction

  logic [0:0]           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        own_q, own_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;

  logic                 any_s;
  logic [PW-1:0]        sel_s;
  logic [PW-1:0]        cur_s;
  logic                 cur_valid_s;
  logic                 int_drdy_s;
  logic                 xfer_s;
  logic [WIDTH-1:0]     mux_data_s;
  logic                 mux_eop_s;
  logic [NUM_PORTS-1:0] p_drdy_s;

`ifdef RING_PKT_ARB_OREG_EN
  logic                 o_srdy_q, o_srdy_d;
  logic [WIDTH-1:0]     o_data_q, o_data_d;
  logic                 o_eop_q, o_eop_d;
`endif

  // Round-robin search: first requesting port starting at ptr.
  always_comb begin
    logic [PW-1:0] idx_v;
    any_s = 1'b0;
    sel_s = ptr_q;
    idx_v = ptr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx_v = wrap_add(ptr_q, k);
      if (!any_s && bus.p_srdy[idx_v]) begin
        any_s = 1'b1;
        sel_s = idx_v;
      end else begin
        any_s = any_s;
      end
    end
  end

  // Forwarding path: pick the active port, mux its beat, steer its drdy.
  always_comb begin
`ifdef RING_PKT_ARB_OREG_EN
    int_drdy_s = !o_srdy_q || bus.o_drdy;
`else
    int_drdy_s = bus.o_drdy;
`endif
    if (state_q == ST_LOCKED) begin
      cur_s       = own_q;
      cur_valid_s = bus.p_srdy[own_q];
    end else begin
      cur_s       = sel_s;
      cur_valid_s = any_s;
    end

    mux_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cur_s == PW'(i)) begin
        mux_data_s = bus.p_data[i*WIDTH +: WIDTH];
      end else begin
        mux_data_s = mux_data_s;
      end
    end
    mux_eop_s = bus.p_eop[cur_s];

    p_drdy_s = {NUM_PORTS{1'b0}};
    if (reset) begin
      p_drdy_s = {NUM_PORTS{1'b0}};
    end else if ((state_q == ST_LOCKED) || any_s) begin
      p_drdy_s[cur_s] = int_drdy_s;
    end else begin
      p_drdy_s = {NUM_PORTS{1'b0}};
    end

    xfer_s = !reset && cur_valid_s && int_drdy_s;
  end

  // Lock/unlock decisions and pointer advance, taken only on a transfer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          if (mux_eop_s) begin
            ptr_d = next_idx(sel_s);
          end else begin
            state_d        = ST_LOCKED;
            own_d          = sel_s;
            grant_d        = {NUM_PORTS{1'b0}};
            grant_d[sel_s] = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (xfer_s && mux_eop_s) begin
          state_d = ST_IDLE;
          ptr_d   = next_idx(own_q);
          grant_d = {NUM_PORTS{1'b0}};
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NUM_PORTS{1'b0}};
      end
    endcase
  end

  // Arbitration state registers; reset abandons any partial packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= {PW{1'b0}};
      own_q   <= {PW{1'b0}};
      grant_q <= {NUM_PORTS{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
    end
  end

  assign bus.p_drdy = p_drdy_s;
  assign bus.grant  = grant_q;

`ifdef RING_PKT_ARB_OREG_EN
  // Output stage loads the mux whenever it is empty or being drained.
  always_comb begin
    if (int_drdy_s) begin
      o_srdy_d = cur_valid_s;
      o_data_d = mux_data_s;
      o_eop_d  = mux_eop_s;
    end else begin
      o_srdy_d = o_srdy_q;
      o_data_d = o_data_q;
      o_eop_d  = o_eop_q;
    end
  end

  // One-entry output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_srdy_q <= 1'b0;
      o_data_q <= {WIDTH{1'b0}};
      o_eop_q  <= 1'b0;
    end else begin
      o_srdy_q <= o_srdy_d;
      o_data_q <= o_data_d;
      o_eop_q  <= o_eop_d;
    end
  end

  assign bus.o_srdy = o_srdy_q;
  assign bus.o_data = o_data_q;
  assign bus.o_eop  = o_eop_q;
`else
  assign bus.o_srdy = cur_valid_s && !reset;
  assign bus.o_data = mux_data_s;
  assign bus.o_eop  = mux_eop_s;
`endif

endmodule

// File: tb/tb_ring_pkt_arb.sv
// tb_ring_pkt_arb: directed bench for ring_pkt_arb. A vector table covers the
// zero-latency build; a beat scoreboard and a 3-port wrap sequence run in
// either build.
module tb_ring_pkt_arb;

`ifdef RING_PKT_ARB_OREG_EN
  localparam bit OREG = 1'b1;
`else
  localparam bit OREG = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ring_pkt_arb_if #(.NUM_PORTS(4), .WIDTH(8)) bus  ();
  ring_pkt_arb_if #(.NUM_PORTS(3), .WIDTH(8)) bus3 ();

  ring_pkt_arb #(.NUM_PORTS(4), .WIDTH(8)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  ring_pkt_arb #(.NUM_PORTS(3), .WIDTH(8)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  srdy;
    logic [3:0]  eop;
    logic [31:0] data;
    logic        odrdy;
    logic [3:0]  x_pdrdy;
    logic        x_osrdy;
    logic [7:0]  x_odata;
    logic        x_oeop;
    logic [3:0]  x_grant;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] srdy, input logic [3:0] eop,
                     input logic [31:0] data, input logic odrdy, input logic [3:0] xp,
                     input logic xs, input logic [7:0] xd, input logic xe, input logic [3:0] xg);
    vec_t v;
    v.rst = rst; v.srdy = srdy; v.eop = eop; v.data = data; v.odrdy = odrdy;
    v.x_pdrdy = xp; v.x_osrdy = xs; v.x_odata = xd; v.x_oeop = xe; v.x_grant = xg;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  logic [7:0]  sb[$];
  logic [5:0]  cnt[4];
  logic [31:0] dword;
  logic [7:0]  bval;
  logic [1:0]  pidx;
  logic [2:0]  eop3[8];
  logic [2:0]  xp3[8];
  logic [2:0]  xg3[8];
  int          rr_exp;
  int          out_beats;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.p_srdy = 4'b0000;  bus.p_eop = 4'b0000;  bus.p_data = 32'h0;  bus.o_drdy = 1'b1;
    bus3.p_srdy = 3'b000;  bus3.p_eop = 3'b000;  bus3.p_data = 24'h0;  bus3.o_drdy = 1'b1;
    repeat (2) @(posedge clk);

`ifndef RING_PKT_ARB_OREG_EN
    // reset with requests pending
    add(1'b1, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000);
    for (int i = 0; i < 10; i++)
      add(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000);
    // round robin of single-beat packets, including wrap 3 -> 0
    add(1'b0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 1'b1, 4'b0000);
    add(1'b0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 1'b1, 4'b0000);
    add(1'b0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b1, 4'b0000);
    add(1'b0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA3, 1'b1, 4'b0000);
    add(1'b0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 1'b1, 4'b0000);
    add(1'b0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 1'b1, 4'b0000);
    // port 2 three-beat packet, port 1 waiting
    add(1'b0, 4'b0110, 4'b0010, 32'h00B0C100, 1'b1, 4'b0100, 1'b1, 8'hB0, 1'b0, 4'b0000);
    add(1'b0, 4'b0110, 4'b0010, 32'h00B1C100, 1'b1, 4'b0100, 1'b1, 8'hB1, 1'b0, 4'b0100);
    add(1'b0, 4'b0110, 4'b0110, 32'h00B2C100, 1'b1, 4'b0100, 1'b1, 8'hB2, 1'b1, 4'b0100);
    add(1'b0, 4'b0010, 4'b0010, 32'h0000C100, 1'b1, 4'b0010, 1'b1, 8'hC1, 1'b1, 4'b0000);
    // port 0 packet with 2 bubbles and 3 cycles of backpressure, port 1 waiting
    add(1'b0, 4'b0011, 4'b0010, 32'h0000F1E0, 1'b1, 4'b0001, 1'b1, 8'hE0, 1'b0, 4'b0000);
    add(1'b0, 4'b0010, 4'b0010, 32'h0000F1E0, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 4'b0001);
    add(1'b0, 4'b0010, 4'b0010, 32'h0000F1E0, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 4'b0001);
    add(1'b0, 4'b0011, 4'b0010, 32'h0000F1E1, 1'b0, 4'b0000, 1'b1, 8'hE1, 1'b0, 4'b0001);
    add(1'b0, 4'b0011, 4'b0010, 32'h0000F1E1, 1'b0, 4'b0000, 1'b1, 8'hE1, 1'b0, 4'b0001);
    add(1'b0, 4'b0011, 4'b0010, 32'h0000F1E1, 1'b0, 4'b0000, 1'b1, 8'hE1, 1'b0, 4'b0001);
    add(1'b0, 4'b0011, 4'b0010, 32'h0000F1E1, 1'b1, 4'b0001, 1'b1, 8'hE1, 1'b0, 4'b0001);
    add(1'b0, 4'b0011, 4'b0011, 32'h0000F1E2, 1'b1, 4'b0001, 1'b1, 8'hE2, 1'b1, 4'b0001);
    add(1'b0, 4'b0010, 4'b0010, 32'h0000F100, 1'b1, 4'b0010, 1'b1, 8'hF1, 1'b1, 4'b0000);
    // idle selection stalled by the sink
    add(1'b0, 4'b1000, 4'b1000, 32'hD3000000, 1'b0, 4'b0000, 1'b1, 8'hD3, 1'b1, 4'b0000);
    add(1'b0, 4'b1000, 4'b1000, 32'hD3000000, 1'b1, 4'b1000, 1'b1, 8'hD3, 1'b1, 4'b0000);
    // reset on beat 2 of a port 3 packet
    add(1'b0, 4'b1000, 4'b0000, 32'h90000000, 1'b1, 4'b1000, 1'b1, 8'h90, 1'b0, 4'b0000);
    add(1'b1, 4'b1001, 4'b0000, 32'h91000055, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b1000);
    add(1'b0, 4'b1001, 4'b1001, 32'h91000055, 1'b1, 4'b0001, 1'b1, 8'h55, 1'b1, 4'b0000);
    add(1'b0, 4'b1000, 4'b1000, 32'h91000000, 1'b1, 4'b1000, 1'b1, 8'h91, 1'b1, 4'b0000);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst;
      bus.p_srdy = tbl[i].srdy;
      bus.p_eop  = tbl[i].eop;
      bus.p_data = tbl[i].data;
      bus.o_drdy = tbl[i].odrdy;
      #4;
      check("p_drdy", i, 32'(bus.p_drdy), 32'(tbl[i].x_pdrdy));
      check("o_srdy", i, 32'(bus.o_srdy), 32'(tbl[i].x_osrdy));
      check("grant",  i, 32'(bus.grant),  32'(tbl[i].x_grant));
      if (tbl[i].x_osrdy) begin
        check("o_data", i, 32'(bus.o_data), 32'(tbl[i].x_odata));
        check("o_eop",  i, 32'(bus.o_eop),  32'(tbl[i].x_oeop));
      end
    end
`endif

    // scoreboard: all ports stream single beats, sink steady then toggling
    @(negedge clk);
    reset = 1'b1;
    bus.p_srdy = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 6'd0;
    rr_exp = 0;
    out_beats = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        pidx = i[1:0];
        bval = {pidx, cnt[i]};
        dword[i*8 +: 8] = bval;
      end
      bus.p_srdy = 4'b1111;
      bus.p_eop  = 4'b1111;
      bus.p_data = dword;
      bus.o_drdy = (c < 12) ? 1'b1 : ((c % 2) == 0);
      #4;
      if (c == 0) check("first o_srdy latency", c, 32'(bus.o_srdy), OREG ? 32'd0 : 32'd1);
      check("p_drdy any", c, 32'(|bus.p_drdy),
            OREG ? 32'(!bus.o_srdy || bus.o_drdy) : 32'(bus.o_drdy));
      if (|bus.p_drdy) begin
        check("rr order", c, 32'(bus.p_drdy), 32'(4'b0001 << rr_exp));
        sb.push_back(dword[rr_exp*8 +: 8]);
        cnt[rr_exp] = cnt[rr_exp] + 6'd1;
        rr_exp = (rr_exp + 1) % 4;
      end
      if (bus.o_srdy && bus.o_drdy) begin
        if (c >= 2 && c < 12) out_beats++;
        if (sb.size() == 0) begin
          check("beat without source", c, 32'(bus.o_data), 32'hFFFF_FFFF);
        end else begin
          check("beat data", c, 32'(bus.o_data), 32'(sb.pop_front()));
        end
      end
      check("grant single", c, 32'(bus.grant), 32'd0);
    end
    check("throughput", 0, 32'(out_beats), 32'd10);

    // 3-port instance: explicit wrap 2 -> 0 and unlock pointer wrap
    eop3 = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b011, 3'b111, 3'b111};
    xp3  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b001};
    xg3  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
    @(negedge clk);
    bus.p_srdy = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      bus3.p_srdy = 3'b111;
      bus3.p_eop  = eop3[c];
      bus3.o_drdy = 1'b1;
      #4;
      check("n3 p_drdy", c, 32'(bus3.p_drdy), 32'(xp3[c]));
      check("n3 grant",  c, 32'(bus3.grant),  32'(xg3[c]));
    end

    @(negedge clk);
    bus3.p_srdy = 3'b000;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_pkt_arb.md
# ring_pkt_arb

Packet-granular round-robin arbiter and mux that shares one srdy/drdy output channel among `NUM_PORTS` srdy/drdy requesters. Once a port wins, the grant locks to it until the beat carrying `p_eop` transfers, so packets are never interleaved. After each packet the next requester in round-robin order wins. It sits in front of the ring/bridge egress, where each ring stop's request is one input.

## Interface
- `NUM_PORTS`, default 4: number of requesters, at least 2.
- `WIDTH`, default 8: data width per beat.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `p_srdy`  in  NUM_PORTS  per-port beat valid.
- `p_drdy`  out  NUM_PORTS  per-port beat accepted; at most one bit set.
- `p_data`  in  NUM_PORTS*WIDTH  port i occupies bits [i*WIDTH +: WIDTH].
- `p_eop`  in  NUM_PORTS  last beat of packet, per port.
- `o_srdy`  out  1  output beat valid.
- `o_drdy`  in  1  downstream accepts.
- `o_data`  out  WIDTH  output beat data.
- `o_eop`  out  1  output end of packet.
- `grant`  out  NUM_PORTS  one-hot, registered lock owner; 0 when not locked.

## Operation
- Internal ready: `int_drdy` equals `o_drdy` in the default build. The Configuration section defines it for the `RING_PKT_ARB_OREG_EN` build.
- Transfer on port i: `p_srdy[i]` and `p_drdy[i]` are both high in the same cycle.
- State: a two-state FSM (IDLE, LOCKED), a round-robin pointer `ptr` of width `$clog2(NUM_PORTS)`, and an owner index `own`.
- IDLE:
  - Selection `sel` is the first port with `p_srdy` set, searching `ptr`, `ptr+1`, … modulo `NUM_PORTS`. The search is combinational.
  - `p_drdy[sel] = int_drdy`. All other `p_drdy` bits are 0.
  - The selected beat's data and eop drive the output path.
  - If no `p_srdy` is set, the output path is invalid and the FSM stays in IDLE.
- IDLE, transfer with `p_eop[sel]=1` (single-beat packet): stay in IDLE; `ptr` ← `sel+1` mod N; `grant` stays 0.
- IDLE, transfer with `p_eop[sel]=0`: go to LOCKED; `own` ← `sel`; `grant` ← `1<<sel`.
- LOCKED:
  - Only port `own` is forwarded; `p_drdy[own] = int_drdy`. All other ports see `p_drdy=0` even if their `p_srdy` is set.
  - If `p_srdy[own]=0` (a bubble), the output path is invalid and the lock is held.
  - Transfer with eop: go to IDLE; `ptr` ← `own+1` mod N; `grant` ← 0.
- Pointer wrap: `ptr` goes from N-1 to 0.
- Non-power-of-2 `NUM_PORTS`: the pointer increment and search wrap explicitly at N. They never rely on natural overflow.
- Reset mid-packet: the FSM returns to IDLE and the partial packet is abandoned. Upstream re-sends.

## Timing
- Reset values:
  - FSM = IDLE, `ptr` = 0, `grant` = 0.
  - `p_drdy` = 0 while `reset` is high.
  - `o_srdy` = 0 while `reset` is high; it is also 0 in the registered build.
- Default build: zero latency. Input to output is combinational.
- The first beat is granted in the same cycle it is presented; there is no arbitration bubble.
- Back-to-back packets from different ports transfer on consecutive cycles.
- `grant` and `ptr` update on the clock edge after the deciding transfer.
- `o_srdy` never depends combinationally on `o_drdy`.
- Handshake: data must be held while srdy is high and drdy is low. The arbiter never switches `sel` while the IDLE selection is stalled, because `ptr` changes only on a transfer.

## Configuration
- `RING_PKT_ARB_OREG_EN` defined:
  - A one-entry output register sits between the mux and the `o_*` ports.
  - `int_drdy = !o_srdy_q | o_drdy`. The register loads the mux output whenever `int_drdy` is high.
  - `o_srdy` is registered.
  - Latency is 1 cycle; sustained throughput is 1 beat per cycle.
  - Reset clears `o_srdy`. `o_data` and `o_eop` are don't-care when `o_srdy`=0.
- `RING_PKT_ARB_OREG_EN` undefined: the output is the combinational mux and `int_drdy = o_drdy`.

## Test plan
- Reset, then hold `p_srdy=4'b0000` and `o_drdy=1`: → `o_srdy=0`, `p_drdy=0`, `grant=0` for 10 cycles.
- All 4 ports present 1-beat packets continuously with `o_drdy=1`: → output port order 0,1,2,3,0,1…; one beat per cycle; `grant` stays 0.
- Port 2 sends a 3-beat packet while port 1 requests:
  - Port 1 is blocked until port 2's eop transfers.
  - `grant=4'b0100` during beats 2–3.
  - Port 1's first beat transfers the cycle after port 2's eop.
- Mid-packet bubbles and backpressure:
  - Stimulus: owner drops `p_srdy` for 2 cycles, and `o_drdy=0` for 3 cycles.
  - Data is held stable, there are no duplicate or lost beats, and the lock is held.
- Reset asserted on beat 2 of a 4-beat packet from port 3: → next cycle FSM=IDLE, `grant=0`, `ptr=0`; port 0 wins if it requests.
- `RING_PKT_ARB_OREG_EN` build:
  - Repeat the round-robin test: each beat appears 1 cycle later, still 1 beat per cycle.
  - Toggle `o_drdy` 1/0: no beat loss, and `p_drdy` follows `!o_srdy | o_drdy`.
